// File: rtl/comp_pkg.sv
// Shared definitions for the sequential magnitude comparator:
// op codes, FSM states and chunk-count helper.
package comp_pkg;

  localparam logic [2:0] OP_EQ = 3'd0;
  localparam logic [2:0] OP_NE = 3'd1;
  localparam logic [2:0] OP_LT = 3'd2;
  localparam logic [2:0] OP_LE = 3'd3;
  localparam logic [2:0] OP_GT = 3'd4;
  localparam logic [2:0] OP_GE = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int nchunk(int n, int c);
    return (n + c - 1) / c;
  endfunction

  function automatic logic op_result(
    logic [2:0] op,
    logic       lt,
    logic       eq,
    logic       gt
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (op == OP_EQ): r = eq;
      (op == OP_NE): r = ~eq;
      (op == OP_LT): r = lt;
      (op == OP_LE): r = lt | eq;
      (op == OP_GT): r = gt;
      (op == OP_GE): r = gt | eq;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comp_lt.sv
// Combinational unsigned less-than for one chunk.
// Kept as a separate unit so it can be swapped for a faster tree.
module comp_lt #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  assign lt = a < b;

endmodule

// File: rtl/comp_mag_seq.sv
// Multi-cycle magnitude comparator: walks operand chunks MSB-first
// and stops at the first chunk that differs.
module comp_mag_seq
  import comp_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  input  logic         sgn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         result,
  output logic         lt,
  output logic         eq,
  output logic         gt,
  output logic         busy
);

  localparam int NCHUNK = nchunk(N, CHUNK);
  localparam int W      = NCHUNK * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t          state;
  logic [W-1:0]    ra;
  logic [W-1:0]    rb;
  logic [2:0]      rop;
  logic [IW-1:0]   idx;

  logic [W-1:0]     ea;
  logic [W-1:0]     eb;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             c_lt;
  logic             c_eq;

  // Flipping the sign bit maps two's complement onto offset binary,
  // so the chunk walk below only ever does unsigned compares.
  always_comb begin
    ea        = '0;
    eb        = '0;
    ea[N-1:0] = a;
    eb[N-1:0] = b;
    if (sgn) begin
      ea[N-1] = ~a[N-1];
      eb[N-1] = ~b[N-1];
    end
  end

  assign ca   = ra[int'(idx)*CHUNK +: CHUNK];
  assign cb   = rb[int'(idx)*CHUNK +: CHUNK];
  assign c_eq = &(ca ~^ cb);

  comp_lt #(
    .N(CHUNK)
  ) u_lt (
    .a (ca),
    .b (cb),
    .lt(c_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rop       <= '0;
      idx       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ra       <= ea;
            rb       <= eb;
            rop      <= op;
            idx      <= IW'(NCHUNK - 1);
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (!c_eq) begin
            lt        <= c_lt;
            gt        <= ~c_lt;
            eq        <= 1'b0;
            result    <= op_result(rop, c_lt, 1'b0, ~c_lt);
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else if (idx == '0) begin
            lt        <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b1;
            result    <= op_result(rop, 1'b0, 1'b1, 1'b0);
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_mag_seq.sv
// Randomised bench for comp_mag_seq across three width/chunk shapes,
// checked against an arithmetic reference model.
module tb_comp_mag_seq;

  localparam int WID [3] = '{8, 5, 32};
  localparam int CHK [3] = '{2, 2, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv   [3];
  logic        ir   [3];
  logic [31:0] a_s  [3];
  logic [31:0] b_s  [3];
  logic [2:0]  op_s [3];
  logic        sg_s [3];
  logic        ov   [3];
  logic        ordy [3];
  logic        res  [3];
  logic        flt  [3];
  logic        feq  [3];
  logic        fgt  [3];
  logic        bsy  [3];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  comp_mag_seq #(.N(8), .CHUNK(2)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_s[0][7:0]), .b(b_s[0][7:0]),
    .op(op_s[0]), .sgn(sg_s[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .result(res[0]), .lt(flt[0]), .eq(feq[0]),
    .gt(fgt[0]), .busy(bsy[0])
  );

  comp_mag_seq #(.N(5), .CHUNK(2)) u5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_s[1][4:0]), .b(b_s[1][4:0]),
    .op(op_s[1]), .sgn(sg_s[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .result(res[1]), .lt(flt[1]), .eq(feq[1]),
    .gt(fgt[1]), .busy(bsy[1])
  );

  comp_mag_seq #(.N(32), .CHUNK(4)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_s[2]), .b(b_s[2]),
    .op(op_s[2]), .sgn(sg_s[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .result(res[2]), .lt(flt[2]), .eq(feq[2]),
    .gt(fgt[2]), .busy(bsy[2])
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction on instance k, with `hold` cycles of backpressure.
  task automatic do_op(
    input int          k,
    input logic [31:0] av_in,
    input logic [31:0] bv_in,
    input logic [2:0]  o,
    input logic        s,
    input int          hold
  );
    int          n, c, nch, m, lat, p;
    logic [31:0] mask, av, bv, x;
    longint      va, vb;
    logic        elt, eeq, egt, eres;
    n    = WID[k];
    c    = CHK[k];
    nch  = (n + c - 1) / c;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    av   = av_in & mask;
    bv   = bv_in & mask;
    va   = longint'(av);
    vb   = longint'(bv);
    if (s && av[n-1]) va = va - (longint'(1) << n);
    if (s && bv[n-1]) vb = vb - (longint'(1) << n);
    elt = va < vb;
    eeq = va == vb;
    egt = va > vb;
    case (o)
      3'd0:    eres = eeq;
      3'd1:    eres = !eeq;
      3'd2:    eres = elt;
      3'd3:    eres = elt | eeq;
      3'd4:    eres = egt;
      3'd5:    eres = egt | eeq;
      default: eres = 1'b0;
    endcase
    x = av ^ bv;
    m = nch;
    if (x != 0) begin
      p = 0;
      for (int i = 0; i < 32; i++) if (x[i]) p = i;
      m = nch - p / c;
    end

    check("ready_idle", ir[k], 1'b1);
    a_s[k]  = av;
    b_s[k]  = bv;
    op_s[k] = o;
    sg_s[k] = s;
    iv[k]   = 1'b1;
    @(posedge clk);
    #1;
    iv[k]   = 1'b0;
    a_s[k]  = $urandom;
    b_s[k]  = $urandom;
    op_s[k] = 3'($urandom);
    sg_s[k] = 1'($urandom);
    check("ready_busy", ir[k], 1'b0);
    check("busy_flag", bsy[k], 1'b1);
    lat = 0;
    while (!ov[k] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, m);
    check("result", res[k], eres);
    check("lt", flt[k], elt);
    check("eq", feq[k], eeq);
    check("gt", fgt[k], egt);
    check("busy_done", bsy[k], 1'b0);

    for (int h = 0; h < hold; h++) begin
      iv[k]  = 1'b1;
      a_s[k] = $urandom;
      b_s[k] = $urandom;
      @(posedge clk);
      #1;
      check("hold_valid", ov[k], 1'b1);
      check("hold_ready", ir[k], 1'b0);
      check("hold_res", {res[k], flt[k], feq[k], fgt[k]},
            {eres, elt, eeq, egt});
    end
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    check("post_valid", ov[k], 1'b0);
    check("post_ready", ir[k], 1'b1);
    check("post_flags", {res[k], flt[k], feq[k], fgt[k]},
          {eres, elt, eeq, egt});
  endtask

  task automatic rand_op(input int k);
    logic [31:0] av, bv;
    int          sel;
    av  = $urandom;
    sel = $urandom_range(0, 3);
    if (sel == 0)      bv = av;
    else if (sel == 1) bv = av ^ (32'd1 << $urandom_range(0, WID[k] - 1));
    else               bv = $urandom;
    do_op(k, av, bv, 3'($urandom), 1'($urandom), $urandom_range(0, 2));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      a_s[k]  = '0;
      b_s[k]  = '0;
      op_s[k] = '0;
      sg_s[k] = 1'b0;
      ordy[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", ir[k], 1'b1);
      check("rst_outs", {ov[k], bsy[k], res[k], flt[k], feq[k], fgt[k]}, '0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(0, 32'h35, 32'h36, 3'd2, 1'b0, 0);
    do_op(0, 32'h80, 32'h01, 3'd4, 1'b0, 0);
    do_op(0, 32'h80, 32'h01, 3'd4, 1'b1, 0);
    do_op(0, 32'hA5, 32'hA5, 3'd3, 1'b0, 0);
    do_op(0, 32'hA5, 32'hA5, 3'd1, 1'b0, 0);
    do_op(0, 32'hA5, 32'hA5, 3'd7, 1'b0, 0);
    do_op(0, 32'h35, 32'h36, 3'd0, 1'b0, 5);
    do_op(1, 32'h10, 32'h0F, 3'd2, 1'b1, 0);
    do_op(1, 32'h10, 32'h0F, 3'd2, 1'b0, 0);
    do_op(2, 32'h8000_0000, 32'h7FFF_FFFF, 3'd5, 1'b1, 1);

    // Abort an in-flight compare with reset.
    a_s[2]  = 32'hDEAD_BEEF;
    b_s[2]  = 32'hDEAD_BEEF;
    op_s[2] = 3'd0;
    sg_s[2] = 1'b0;
    iv[2]   = 1'b1;
    @(posedge clk);
    #1;
    iv[2] = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", bsy[2], 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {ov[2], bsy[2], res[2], flt[2], feq[2], fgt[2]}, '0);
    check("abort_ready", ir[2], 1'b1);
    #3;
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (12) begin
        @(posedge clk);
        #1;
        seen = seen | ov[2];
      end
      check("abort_no_valid", seen, 1'b0);
      check("abort_ready_rel", ir[2], 1'b1);
    end

    for (int r = 0; r < 40; r++) begin
      rand_op(0);
      rand_op(1);
      rand_op(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
